// File: rtl/pio_request_pkg.sv
// Shared FSM state type, register map and status layout for the PIO request arbiter.
package pio_request_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ACK     = 2'd2;
  localparam logic [1:0] ADDR_CLEAR   = 2'd3;

  // Index width covers the full 1..8 requester range.
  localparam int unsigned IDX_W = 3;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_TIMEOUT_BIT = 1;
  localparam int unsigned STATUS_IDX_LSB     = 8;
  localparam int unsigned STATUS_IDX_W       = 8;

endpackage

// File: rtl/pio_request_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index after last_grant, wrapping.
module rr_picker
  import pio_request_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!valid && pending[i] && (((32'(last_grant) + k) % NUM_REQ) == i)) begin
          valid = 1'b1;
          index = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pio_request_arbiter.sv
// Round-robin request arbiter driving an edge-captured PIO line via an Avalon-MM slave.
// Optional grant watchdog enabled by defining PIO_REQ_TIMEOUT_EN.
module pio_request_arbiter
  import pio_request_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               request_out,
  output logic [NUM_REQ-1:0] grant_onehot
);

  localparam int unsigned GAP_EFF = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
  localparam int unsigned GAP_W   = $clog2(GAP_EFF);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               request_out_q, request_out_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [31:0]        status;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               wr_en, ack_wr, clr_wr, ack_fire;
  logic               timeout_hit, tmo_flag;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign pick_onehot = NUM_REQ'(1) << pick_idx;
  assign wr_en       = chipselect && !write_n;
  assign ack_wr      = wr_en && (address == ADDR_ACK) && writedata[0];
  assign clr_wr      = wr_en && (address == ADDR_CLEAR);
  assign ack_fire    = (state_q == GRANT) && ack_wr;

`ifdef PIO_REQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              ack_reg_wr;

  assign ack_reg_wr  = wr_en && (address == ADDR_ACK);
  assign timeout_hit = (state_q == GRANT) && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign tmo_flag    = tmo_flag_q;

  always_comb begin
    wdog_d     = (state_q == GRANT) ? wdog_q + 1'b1 : '0;
    tmo_flag_d = tmo_flag_q;
    // Any write to the ack register clears the flag, except when an ack collides with a timeout.
    if (!(timeout_hit && ack_fire)) begin
      if (timeout_hit)     tmo_flag_d = 1'b1;
      else if (ack_reg_wr) tmo_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q     <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign tmo_flag           = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:NUM_REQ];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    grant_d      = grant_q;
    gap_d        = '0;
    pending_d    = pending_q;
    if (clr_wr) pending_d = pending_d & ~writedata[NUM_REQ-1:0];
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = GRANT;
          last_grant_d = pick_idx;
          grant_idx_d  = pick_idx;
          grant_d      = pick_onehot;
          pending_d    = pending_d & ~pick_onehot;
        end
      end
      GRANT: begin
        if (ack_fire || timeout_hit) begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_EFF - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // A new strobe always wins over a same-cycle grant or clear.
    pending_d     = pending_d | req_in;
    request_out_d = (state_d == GRANT);
  end

  always_comb begin
    status = '0;
    status[STATUS_IDX_LSB +: STATUS_IDX_W] = STATUS_IDX_W'(grant_idx_q);
    status[STATUS_TIMEOUT_BIT]             = tmo_flag;
    status[STATUS_BUSY_BIT]                = (state_q != IDLE);
    unique case (address)
      ADDR_STATUS:  readdata_d = status;
      ADDR_PENDING: readdata_d = 32'(pending_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      grant_idx_q   <= '0;
      grant_q       <= '0;
      request_out_q <= 1'b0;
      gap_q         <= '0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_q       <= grant_d;
      request_out_q <= request_out_d;
      gap_q         <= gap_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign request_out  = request_out_q;
  assign grant_onehot = grant_q;

endmodule
